// File: rtl/bp_core_lce_req_merge.sv
// Merges the core's two LCE request channels (0 = I$, 1 = D$) onto a single
// valid/ready LCE request link. Each channel is buffered in a small FIFO.
// Sources are round-robin arbitrated, and a multi-beat message keeps the grant
// until its last beat has transferred.
//
// Ports:
//   clk_i, reset_i       clock, synchronous active-high reset
//   msg_i/last_i/v_i     per-channel request beat, last-beat flag, valid
//   ready_o              per-channel FIFO can accept (registered)
//   msg_o/last_o/src_o   merged beat, last-beat flag, source channel
//   v_o / ready_i        merged beat valid / downstream accepts
module bp_core_lce_req_merge #(
  parameter int unsigned msg_width_p = 128,
  parameter int unsigned fifo_els_p  = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [1:0][msg_width_p-1:0] msg_i,
  input  logic [1:0]                  last_i,
  input  logic [1:0]                  v_i,
  output logic [1:0]                  ready_o,
  output logic [msg_width_p-1:0]      msg_o,
  output logic                        last_o,
  output logic                        src_o,
  output logic                        v_o,
  input  logic                        ready_i
);

  localparam int unsigned ptr_w_lp  = $clog2(fifo_els_p);
  localparam int unsigned beat_w_lp = msg_width_p + 1;

  logic [1:0]           empty;
  logic [1:0]           enq;
  logic [1:0]           deq;
  logic [beat_w_lp-1:0] head [2];
  logic                 grant;
  logic                 xfer;
  logic                 lock_r;
  logic                 rr_r;
  logic                 src_r;
  logic                 stall_r;

  // Per-channel FIFO: {last, msg} entries, wrapping pointers plus full/empty bits.
  for (genvar i = 0; i < 2; i++) begin : g_fifo
    logic [beat_w_lp-1:0] mem_r [fifo_els_p];
    logic [ptr_w_lp-1:0]  rd_r;
    logic [ptr_w_lp-1:0]  wr_r;
    logic [ptr_w_lp-1:0]  rd_nx;
    logic [ptr_w_lp-1:0]  wr_nx;
    logic                 full_r;
    logic                 empty_r;
    logic                 ready_r;

    assign rd_nx      = rd_r + ptr_w_lp'(1);
    assign wr_nx      = wr_r + ptr_w_lp'(1);
    assign enq[i]     = v_i[i] & ready_r;
    assign deq[i]     = xfer & (grant == 1'(i));
    assign empty[i]   = empty_r;
    assign ready_o[i] = ready_r;
    assign head[i]    = mem_r[rd_r];

    // Storage needs no reset; it is only read while non-empty.
    always_ff @(posedge clk_i) begin
      if (enq[i]) mem_r[wr_r] <= {last_i[i], msg_i[i]};
    end

    // ready_r tracks the post-update fullness, so a full FIFO re-opens the
    // cycle after it is dequeued, never in the same cycle.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        rd_r    <= '0;
        wr_r    <= '0;
        full_r  <= 1'b0;
        empty_r <= 1'b1;
        ready_r <= 1'b0;
      end else begin
        if (enq[i]) wr_r <= wr_nx;
        if (deq[i]) rd_r <= rd_nx;
        if (enq[i] & ~deq[i]) begin
          empty_r <= 1'b0;
          full_r  <= (wr_nx == rd_r);
          ready_r <= (wr_nx != rd_r);
        end else if (deq[i] & ~enq[i]) begin
          full_r  <= 1'b0;
          empty_r <= (rd_nx == wr_r);
          ready_r <= 1'b1;
        end else begin
          ready_r <= ~full_r;
        end
      end
    end
  end

  // Grant: hold the previous source while locked or while a presented beat is
  // stalled (keeps the offered beat stable); otherwise round-robin.
  always_comb begin
    grant = src_r;
    if (!(lock_r | stall_r)) begin
      if (~empty[0] & ~empty[1]) grant = rr_r;
      else if (~empty[1])        grant = 1'b1;
      else if (~empty[0])        grant = 1'b0;
    end
  end

  assign v_o    = ~empty[grant];
  assign xfer   = v_o & ready_i;
  assign src_o  = grant;
  assign msg_o  = v_o ? head[grant][msg_width_p-1:0] : '0;
  assign last_o = v_o & head[grant][msg_width_p];

  // Arbitration state: lock and rr pointer move only on a transfer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lock_r  <= 1'b0;
      rr_r    <= 1'b0;
      src_r   <= 1'b0;
      stall_r <= 1'b0;
    end else begin
      stall_r <= v_o & ~ready_i;
      if (v_o) src_r <= grant;
      if (xfer) begin
        if (last_o) begin
          lock_r <= 1'b0;
          rr_r   <= ~grant;
        end else begin
          lock_r <= 1'b1;
        end
      end
    end
  end

  // Simulation checks.
  a_els: assert property (@(posedge clk_i)
    (fifo_els_p >= 2) && ((fifo_els_p & (fifo_els_p - 1)) == 0));

  a_src_locked: assert property (@(posedge clk_i) disable iff (reset_i)
    (lock_r && $past(lock_r)) |-> $stable(src_o));

  for (genvar i = 0; i < 2; i++) begin : g_hold
    a_hold: assert property (@(posedge clk_i) disable iff (reset_i)
      (v_i[i] & ~ready_o[i]) |=> v_i[i]);
  end

endmodule

// File: tb/tb_bp_core_lce_req_merge.sv
// Randomized and directed bench for bp_core_lce_req_merge with a scoreboard:
// accepted beats are queued per channel, and a negedge monitor applies the
// arbitration rules (lock, round-robin, stall stability) to pick the expected
// beat and compare it with the DUT outputs.
module tb_bp_core_lce_req_merge;

  localparam int unsigned W   = 16;
  localparam int unsigned ELS = 2;

  typedef struct packed {
    logic [W-1:0] msg;
    logic         last;
    logic [1:0]   gap;
  } beat_t;

  logic            clk;
  logic            reset_i;
  logic [1:0][W-1:0] msg_i;
  logic [1:0]      last_i;
  logic [1:0]      v_i;
  logic [1:0]      ready_o;
  logic [W-1:0]    msg_o;
  logic            last_o;
  logic            src_o;
  logic            v_o;
  logic            ready_i;

  bp_core_lce_req_merge #(.msg_width_p(W), .fifo_els_p(ELS)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .msg_i   (msg_i),
    .last_i  (last_i),
    .v_i     (v_i),
    .ready_o (ready_o),
    .msg_o   (msg_o),
    .last_o  (last_o),
    .src_o   (src_o),
    .v_o     (v_o),
    .ready_i (ready_i)
  );

  int n_vec = 0;
  int n_err = 0;

  beat_t sq0[$], sq1[$];            // beats waiting to be offered
  beat_t eq0[$], eq1[$];            // accepted beats, awaiting output
  beat_t cur0, cur1;
  logic [W-1:0] out_log[$];
  logic [W-1:0] exp_log[$];
  logic rand_ready = 1'b0;
  int unsigned wait0 = 0, wait1 = 0;

  // reference model state
  logic rst_prev = 1'b0, started = 1'b0;
  logic m_lock = 1'b0, m_cur = 1'b0, m_rr = 1'b0, m_last_src = 1'b0;
  logic m_pend = 1'b0, m_pend_src = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
    $fatal(1, "watchdog");
  end

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: model state after the edge, compare, then account for this cycle.
  always @(negedge clk) begin : mon
    int sz0, sz1;
    logic exp_v, exp_src;
    logic [1:0] exp_rdy;
    beat_t hb;
    if (rst_prev) begin
      eq0.delete(); eq1.delete();
      m_lock = 1'b0; m_rr = 1'b0; m_last_src = 1'b0; m_pend = 1'b0;
      started = 1'b1;
    end
    if (started) begin
      sz0 = eq0.size();
      sz1 = eq1.size();
      exp_rdy = rst_prev ? 2'b00 : {sz1 < int'(ELS), sz0 < int'(ELS)};
      check("ready_o", 64'(ready_o), 64'(exp_rdy));
      exp_v = 1'b0;
      exp_src = m_last_src;
      if (m_lock) begin
        exp_src = m_cur;
        exp_v = m_cur ? (sz1 > 0) : (sz0 > 0);
      end else if (m_pend) begin
        exp_src = m_pend_src; exp_v = 1'b1;
      end else if (sz0 > 0 && sz1 > 0) begin
        exp_src = m_rr; exp_v = 1'b1;
      end else if (sz1 > 0) begin
        exp_src = 1'b1; exp_v = 1'b1;
      end else if (sz0 > 0) begin
        exp_src = 1'b0; exp_v = 1'b1;
      end
      check("v_o", 64'(v_o), 64'(exp_v));
      check("src_o", 64'(src_o), 64'(exp_src));
      if (exp_v) begin
        hb = exp_src ? eq1[0] : eq0[0];
        check("msg_o", 64'(msg_o), 64'(hb.msg));
        check("last_o", 64'(last_o), 64'(hb.last));
        if (ready_i) begin
          if (exp_src) void'(eq1.pop_front()); else void'(eq0.pop_front());
          out_log.push_back(hb.msg);
          if (hb.last) begin
            m_lock = 1'b0; m_rr = ~exp_src;
          end else begin
            m_lock = 1'b1; m_cur = exp_src;
          end
        end
        m_last_src = exp_src;
      end else if (rst_prev) begin
        check("msg_o reset", 64'(msg_o), 64'd0);
        check("last_o reset", 64'(last_o), 64'd0);
      end
      m_pend = exp_v & ~ready_i;
      m_pend_src = exp_src;
    end
    rst_prev = reset_i;
  end

  // One clock: record accepted beats, then offer the next beats (inputs held until taken).
  task automatic tick();
    logic [1:0] acc;
    @(negedge clk);
    acc = v_i & ready_o & {2{~reset_i}};
    @(posedge clk);
    #1;
    if (acc[0]) begin eq0.push_back(cur0); v_i[0] = 1'b0; end
    if (acc[1]) begin eq1.push_back(cur1); v_i[1] = 1'b0; end
    if (rand_ready) ready_i = ($urandom_range(0, 99) < 70);
    if (!v_i[0] && sq0.size() > 0 && !reset_i) begin
      if (wait0 < 32'(sq0[0].gap)) wait0++;
      else begin
        cur0 = sq0.pop_front(); wait0 = 0;
        msg_i[0] = cur0.msg; last_i[0] = cur0.last; v_i[0] = 1'b1;
      end
    end
    if (!v_i[1] && sq1.size() > 0 && !reset_i) begin
      if (wait1 < 32'(sq1[0].gap)) wait1++;
      else begin
        cur1 = sq1.pop_front(); wait1 = 0;
        msg_i[1] = cur1.msg; last_i[1] = cur1.last; v_i[1] = 1'b1;
      end
    end
  endtask

  function automatic void push(logic ch, logic [W-1:0] m, logic l, logic [1:0] g);
    if (ch) sq1.push_back('{msg: m, last: l, gap: g});
    else    sq0.push_back('{msg: m, last: l, gap: g});
  endfunction

  task automatic drain(string name);
    int k;
    k = 0;
    while ((sq0.size() + sq1.size() + eq0.size() + eq1.size()) != 0 || v_i != 2'b00) begin
      if (k >= 2000) break;
      tick();
      k++;
    end
    check({name, " drained"}, 64'(sq0.size() + sq1.size() + eq0.size() + eq1.size()), 64'd0);
    tick();
  endtask

  task automatic check_log(string name);
    check({name, " count"}, 64'(out_log.size()), 64'(exp_log.size()));
    for (int k = 0; k < exp_log.size() && k < out_log.size(); k++)
      check(name, 64'(out_log[k]), 64'(exp_log[k]));
    out_log.delete();
    exp_log.delete();
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    v_i = 2'b00;
    sq0.delete(); sq1.delete();
    wait0 = 0; wait1 = 0;
    tick();
    reset_i = 1'b0;
  endtask

  task automatic gen_random();
    int len;
    for (int m = 0; m < 40; m++) begin
      for (int ch = 0; ch < 2; ch++) begin
        len = $urandom_range(1, 3);
        for (int b = 0; b < len; b++)
          push(1'(ch), 16'(ch * 'h1000 + m * 4 + b), (b == len - 1),
               ($urandom_range(0, 1) != 0) ? 2'($urandom_range(0, 2)) : 2'd0);
      end
    end
  endtask

  initial begin
    reset_i = 1'b1;
    v_i = 2'b00;
    last_i = 2'b00;
    msg_i = '0;
    ready_i = 1'b0;
    repeat (3) tick();
    reset_i = 1'b0;

    // single beat on channel 1
    ready_i = 1'b1;
    push(1'b1, 16'hA5, 1'b1, 2'd0);
    exp_log.push_back(16'hA5);
    drain("single");
    check_log("single order");

    // round-robin alternation
    for (int k = 0; k < 3; k++) begin
      push(1'b0, 16'(16'h10 + k), 1'b1, 2'd0);
      push(1'b1, 16'(16'h20 + k), 1'b1, 2'd0);
    end
    exp_log = '{16'h10, 16'h20, 16'h11, 16'h21, 16'h12, 16'h22};
    drain("rr");
    check_log("rr order");

    // multi-beat lock with a 2-cycle bubble before the second beat
    push(1'b1, 16'h30, 1'b0, 2'd0);
    push(1'b1, 16'h31, 1'b0, 2'd2);
    push(1'b1, 16'h32, 1'b1, 2'd0);
    push(1'b0, 16'h40, 1'b1, 2'd1);
    exp_log = '{16'h30, 16'h31, 16'h32, 16'h40};
    drain("lock");
    check_log("lock order");

    // backpressure fills channel 0
    ready_i = 1'b0;
    push(1'b0, 16'h60, 1'b1, 2'd0);
    push(1'b0, 16'h61, 1'b1, 2'd0);
    push(1'b0, 16'h62, 1'b1, 2'd0);
    repeat (4) tick();
    check("full ready_o0", 64'(ready_o[0]), 64'd0);
    check("full v_o", 64'(v_o), 64'd1);
    check("full msg_o", 64'(msg_o), 64'h60);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("reopen ready_o0", 64'(ready_o[0]), 64'd1);
    tick();
    check("refill ready_o0", 64'(ready_o[0]), 64'd0);
    check("refill msg_o", 64'(msg_o), 64'h61);
    ready_i = 1'b1;
    exp_log = '{16'h60, 16'h61, 16'h62};
    drain("bp");
    check_log("bp order");

    // reset in the middle of a locked message
    push(1'b0, 16'h50, 1'b0, 2'd0);
    for (int k = 0; k < 20 && out_log.size() == 0; k++) tick();
    check("lock setup transfers", 64'(out_log.size()), 64'd1);
    out_log.delete();
    do_reset();
    check("post reset ready_o", 64'(ready_o), 64'd0);
    check("post reset v_o", 64'(v_o), 64'd0);
    tick();
    check("reopen ready_o", 64'(ready_o), 64'h3);
    push(1'b1, 16'h55, 1'b1, 2'd0);
    ready_i = 1'b0;
    tick();
    tick();
    check("fresh v_o", 64'(v_o), 64'd1);
    check("fresh src_o", 64'(src_o), 64'd1);
    check("fresh msg_o", 64'(msg_o), 64'h55);
    ready_i = 1'b1;
    exp_log.push_back(16'h55);
    drain("reset");
    check_log("reset order");

    // simultaneous arrival after reset: channel 0 first
    do_reset();
    push(1'b0, 16'h70, 1'b1, 2'd0);
    push(1'b1, 16'h71, 1'b1, 2'd0);
    exp_log = '{16'h70, 16'h71};
    drain("simul");
    check_log("simul order");

    // randomized traffic with random backpressure
    rand_ready = 1'b1;
    gen_random();
    drain("random");
    rand_ready = 1'b0;
    ready_i = 1'b1;
    out_log.delete();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bp_core_lce_req_merge.md
Name: bp_core_lce_req_merge

Overview:
- Merges the core's two LCE request channels onto the single LCE request link toward the CCE network: channel 0 is the I$ LCE, channel 1 is the D$ LCE.
- Each channel is buffered in a small FIFO. Sources are picked by round-robin arbitration, and a multi-beat message holds the grant until its last beat.
- The upstream side is the core's valid/ready request outputs; the downstream side is a single valid/ready link.

Parameters:
- msg_width_p, 128, width of one request beat (header or data)
- fifo_els_p, 2, entries per input FIFO; must be ≥2 and a power of two

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- msg_i  in  [1:0][msg_width_p]  request beat per channel (0 = I$, 1 = D$)
- last_i  in  [1:0]  beat is the final beat of its message
- v_i  in  [1:0]  beat valid
- ready_o  out  [1:0]  channel FIFO can accept; depends on state only, never on v_i or ready_i
- msg_o  out  msg_width_p  merged beat
- last_o  out  1  merged beat is the last beat of its message
- src_o  out  1  channel the current beat came from
- v_o  out  1  merged beat valid
- ready_i  in  1  downstream accepts

Behaviour:
- Reset state (while reset_i high and the cycle after): ready_o=2'b00, v_o=0, src_o=0, last_o=0, msg_o=0.
  - Both FIFOs empty, rr pointer=0, lock clear.
- Input enqueue: a beat enqueues on channel i when v_i[i] & ready_o[i].
  - ready_o[i] = ~full[i], registered.
  - A full FIFO does not accept in the same cycle it is dequeued; ready_o[i] rises the cycle after the dequeue.
- Latency: a beat enqueued in cycle t is visible on msg_o no earlier than t+1 (no bypass).
- Output: v_o, msg_o, last_o and src_o come combinationally from the head of the granted FIFO.
  - A beat transfers when v_o & ready_i; that cycle the granted FIFO dequeues.
- Grant selection, when lock is clear:
  - If only one FIFO is non-empty, grant that FIFO.
  - If both are non-empty, grant the channel equal to the rr pointer.
  - If both are empty, v_o=0 and the grant is don't-care, but src_o holds its last value.
- Lock:
  - Set when a beat with last=0 transfers; the grant stays on that channel.
  - While locked, v_o = ~empty[granted]. The other channel's data is never interleaved, even while the granted FIFO is empty.
  - Cleared when a beat with last=1 transfers.
- rr pointer: on each transfer of a last=1 beat from channel i, the pointer becomes ~i. It never changes on non-last beats or on idle cycles.
- Stability: once v_o=1 with ready_i=0, msg_o, last_o and src_o hold unchanged until the transfer.
  - Lock/rr state changes only on transfer, which guarantees this.
- FIFO occupancy: per-channel read/write pointers wrap modulo fifo_els_p, plus a full/empty bit.
  - Simultaneous enqueue and dequeue on a non-full FIFO leaves the count unchanged.
- Reset mid-message: reset_i clears FIFOs, lock and rr pointer synchronously; partial messages are discarded.
  - Upstream is also in reset, so no recovery is needed.
- Assertions (sim only):
  - v_i[i] & ~ready_o[i] never drops data; upstream must hold.
  - src_o never changes while locked.
  - fifo_els_p ≥ 2.

Test Plan:
- Single-beat, channel 1 only: after reset, v_i=2'b10, last_i=2'b10, msg_i[1]=0xA5 for 1 cycle, ready_i=1.
  - Required: next cycle v_o=1, msg_o=0xA5, src_o=1, last_o=1; following cycle v_o=0.
- Round-robin fairness: both channels continuously enqueue single-beat messages (ch0 0x10,0x11,..., ch1 0x20,0x21,...), ready_i=1.
  - Required output order: 0x10,0x20,0x11,0x21,0x12,0x22.
- Multi-beat lock: ch1 sends 3 beats 0x30,0x31,0x32(last); ch0 sends single beat 0x40 one cycle after the first ch1 beat.
  - Required output: 0x30,0x31,0x32, then 0x40, with src_o=1 for the first three beats.
  - Insert a 2-cycle bubble before 0x31: v_o=0 during the bubble and 0x40 does not appear.
- Backpressure/full: ready_i=0, ch0 offers 3 single beats back-to-back.
  - Required: ready_o[0] drops after 2 accepts (fifo_els_p=2); v_o=1 and msg_o is stable at the first beat.
  - Raise ready_i for one cycle: ready_o[0] returns 1 the next cycle, and the third beat enqueues.
- Reset mid-message: ch0 beat 0x50 (last=0) has transferred and lock is set; assert reset_i for 1 cycle.
  - Required: the cycle after reset v_o=0, ready_o=2'b00; then ready_o=2'b11.
  - A fresh ch1 single beat is granted immediately (no stale lock).
- Simultaneous arrival after reset: both channels enqueue in the same cycle.
  - Required: ch0 is granted first (rr pointer=0), then ch1.
